// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: wait-state data memory for the MEM stage.
// Accepts a load/store in IDLE, counts down the configured latency, commits
// on the edge into ACK and pulses Ack for one cycle.  Stall holds the
// pipeline while a request is outstanding.
// Optional build macro DMEM_STALL_CNT_EN adds a saturating stall counter
// (Stall_Count output, Stall_Count_Clr input).
//
// state | meaning
// IDLE  | no access in flight; samples op, address and store data
// WAIT  | access accepted, latency counter running
// ACK   | access committed, Ack (and Err) high for this cycle only
module dmem_wait_responder #(
    parameter int DEPTH     = 64,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Ack,
    output logic        Stall,
`ifdef DMEM_STALL_CNT_EN
    input  logic        Stall_Count_Clr,
    output logic [15:0] Stall_Count,
`endif
    output logic        Err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic            accept;
    logic            commit;

    logic            rd_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            in_err;
    logic [3:0]      in_lat;
    logic            c_rd;
    logic            c_err;
    logic [AW-1:0]   c_idx;
    logic [31:0]     c_wdata;

    assign req    = MemRead | MemWrite;
    // Both strobes together is an error; it takes the read latency.
    assign in_err = (MemRead & MemWrite) | (|Address[1:0]) | (|Address[31:AW+2]);
    assign in_lat = MemRead ? 4'(READ_LAT) : 4'(WRITE_LAT);

    // With a latency of one the commit happens on the accepting edge, so the
    // operands come straight from the inputs rather than the capture regs.
    assign c_rd    = (state == IDLE) ? MemRead            : rd_q;
    assign c_err   = (state == IDLE) ? in_err             : err_q;
    assign c_idx   = (state == IDLE) ? Address[AW+1:2]    : idx_q;
    assign c_wdata = (state == IDLE) ? Write_data         : wdata_q;

    assign Ack   = (state == ACK);
    assign Err   = (state == ACK) & err_q;
    assign Stall = req & ~Ack;

    // Next-state, latency countdown, accept and commit strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_nxt = in_lat - 4'd1;
                    if (in_lat == 4'd1) begin
                        state_nxt = ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_nxt = ACK;
                    commit    = 1'b1;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, request capture, array and load data registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            Read_data <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                rd_q    <= MemRead;
                err_q   <= in_err;
                idx_q   <= Address[AW+1:2];
                wdata_q <= Write_data;
            end
            if (commit) begin
                if (c_err) begin
                    Read_data <= 32'd0;
                end else if (c_rd) begin
                    Read_data <= mem[c_idx];
                end else begin
                    mem[c_idx] <= c_wdata;
                end
            end
        end
    end

`ifdef DMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stalled cycles; clear wins over increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_q <= 16'd0;
        end else if (Stall_Count_Clr) begin
            stall_cnt_q <= 16'd0;
        end else if (Stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: two instances (latencies 2/1 and 4/3)
// checked against a behavioural memory model and expected Ack timing.
module tb_dmem_wait_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        stall [2];
    logic        err   [2];
`ifdef DMEM_STALL_CNT_EN
    logic        clr   [2];
    logic [15:0] sc    [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int          lat_rd [2] = '{2, 4};
    int          lat_wr [2] = '{1, 3};
    logic [31:0] mem_m  [2][64];
    logic [31:0] rdata_m[2];

    always #5 CLK = ~CLK;

    dmem_wait_responder #(.DEPTH(64), .READ_LAT(2), .WRITE_LAT(1)) dut_a (
        .CLK(CLK), .RST(RST), .MemRead(rd[0]), .MemWrite(wr[0]),
        .Address(addr[0]), .Write_data(wd[0]), .Read_data(rdata[0]),
        .Ack(ack[0]), .Stall(stall[0]),
`ifdef DMEM_STALL_CNT_EN
        .Stall_Count_Clr(clr[0]), .Stall_Count(sc[0]),
`endif
        .Err(err[0])
    );

    dmem_wait_responder #(.DEPTH(64), .READ_LAT(4), .WRITE_LAT(3)) dut_b (
        .CLK(CLK), .RST(RST), .MemRead(rd[1]), .MemWrite(wr[1]),
        .Address(addr[1]), .Write_data(wd[1]), .Read_data(rdata[1]),
        .Ack(ack[1]), .Stall(stall[1]),
`ifdef DMEM_STALL_CNT_EN
        .Stall_Count_Clr(clr[1]), .Stall_Count(sc[1]),
`endif
        .Err(err[1])
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rdata_m[d] = 32'd0;
            for (int i = 0; i < 64; i++) mem_m[d][i] = 32'd0;
        end
    endtask

    // One access on instance d, starting just after a rising edge.
    // drop_at in 1..lat-1 withdraws the request in that cycle (abort).
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] dat,
                          input int drop_at, input bit hold, input string tag);
        bit e;
        int lat;
        logic [31:0] a_word;
        e = (r && w) || (a[1:0] != 2'd0) || ((a >> 2) >= 64);
        lat = r ? lat_rd[d] : lat_wr[d];
        a_word = a >> 2;
        rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = dat;
        if (drop_at > 0 && drop_at < lat) begin
            for (int c = 0; c <= lat + 1; c++) begin
                if (c == drop_at) begin rd[d] = 1'b0; wr[d] = 1'b0; end
                @(negedge CLK);
                n_checks++;
                if (ack[d] !== 1'b0) begin n_fail++; $display("FAIL %s abort_ack c=%0d got %b want 0", tag, c, ack[d]); end
                n_checks++;
                if (stall[d] !== (c < drop_at)) begin n_fail++; $display("FAIL %s abort_stall c=%0d got %b want %b", tag, c, stall[d], (c < drop_at)); end
                @(posedge CLK); #1;
            end
        end else begin
            for (int c = 0; c <= lat; c++) begin
                @(negedge CLK);
                n_checks++;
                if (ack[d] !== (c == lat)) begin n_fail++; $display("FAIL %s ack c=%0d got %b want %b", tag, c, ack[d], (c == lat)); end
                n_checks++;
                if (stall[d] !== (c != lat)) begin n_fail++; $display("FAIL %s stall c=%0d got %b want %b", tag, c, stall[d], (c != lat)); end
                if (c == lat) begin
                    if (e) rdata_m[d] = 32'd0;
                    else if (r) rdata_m[d] = mem_m[d][a_word[5:0]];
                    else mem_m[d][a_word[5:0]] = dat;
                    n_checks++;
                    if (err[d] !== e) begin n_fail++; $display("FAIL %s err got %b want %b", tag, err[d], e); end
                    n_checks++;
                    if (rdata[d] !== rdata_m[d]) begin n_fail++; $display("FAIL %s rdata got %h want %h", tag, rdata[d], rdata_m[d]); end
                end
                @(posedge CLK); #1;
            end
            if (!hold) begin rd[d] = 1'b0; wr[d] = 1'b0; end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'd0; wd[d] = 32'd0;
`ifdef DMEM_STALL_CNT_EN
            clr[d] = 1'b0;
`endif
        end
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        rd[0] = 1'b1; rd[1] = 1'b1;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err d=%0d got %b%b want 00", d, ack[d], err[d]); end
            n_checks++;
            if (rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata d=%0d got %h want 0", d, rdata[d]); end
            n_checks++;
            if (stall[d] !== 1'b1) begin n_fail++; $display("FAIL reset_stall d=%0d got %b want 1", d, stall[d]); end
        end
        rd[0] = 1'b0; rd[1] = 1'b0;
        #1;
        n_checks++;
        if (stall[0] !== 1'b0) begin n_fail++; $display("FAIL reset_stall_low got %b want 0", stall[0]); end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_default_read();
        access(0, 1'b1, 1'b0, 32'h8, 32'd0, 0, 1'b0, "rd_default");
    endtask

    task automatic test_store_load();
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, "store_a");
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 0, 1'b0, "load_a");
        access(1, 1'b0, 1'b1, 32'h3C, 32'h0BADF00D, 0, 1'b0, "store_b");
        access(1, 1'b1, 1'b0, 32'h3C, 32'd0, 0, 1'b0, "load_b");
    endtask

    task automatic test_errors();
        access(0, 1'b1, 1'b0, 32'h102, 32'd0, 0, 1'b0, "err_misaligned");
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 0, 1'b0, "reload");
        access(0, 1'b1, 1'b0, 32'h100, 32'd0, 0, 1'b0, "err_range");
        access(0, 1'b1, 1'b1, 32'h10, 32'h55555555, 0, 1'b0, "err_both");
        access(0, 1'b0, 1'b1, 32'h12, 32'h66666666, 0, 1'b0, "err_wr_misaligned");
        access(0, 1'b0, 1'b1, 32'hFC, 32'h77777777, 0, 1'b0, "wr_last_word");
        access(0, 1'b0, 1'b1, 32'h8000_0000, 32'h88888888, 0, 1'b0, "err_wr_high");
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 0, 1'b0, "check_unchanged");
        access(0, 1'b1, 1'b0, 32'hFC, 32'd0, 0, 1'b0, "check_last_word");
    endtask

    task automatic test_abort();
        access(1, 1'b1, 1'b0, 32'h8, 32'd0, 2, 1'b0, "abort_rd");
        access(1, 1'b1, 1'b0, 32'h3C, 32'd0, 0, 1'b0, "after_abort_rd");
        access(1, 1'b0, 1'b1, 32'h20, 32'h0000CAFE, 1, 1'b0, "abort_wr");
        access(1, 1'b1, 1'b0, 32'h20, 32'd0, 0, 1'b0, "abort_wr_check");
    endtask

    task automatic test_reset_mid();
        rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h4; wd[1] = 32'h1234;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        n_checks++;
        if (ack[1] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_in_reset got %b want 0", ack[1]); end
        @(posedge CLK); #1;
        wr[1] = 1'b0;
        RST = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_checks++;
            if (ack[1] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack c=%0d got %b want 0", c, ack[1]); end
            @(posedge CLK); #1;
        end
        access(1, 1'b1, 1'b0, 32'h4, 32'd0, 0, 1'b0, "rstmid_word1");
        access(1, 1'b1, 1'b0, 32'h3C, 32'd0, 0, 1'b0, "rstmid_other");
    endtask

    task automatic test_back_to_back();
        access(0, 1'b0, 1'b1, 32'h0, 32'h11111111, 0, 1'b1, "b2b_w0");
        access(0, 1'b0, 1'b1, 32'h4, 32'h22222222, 0, 1'b1, "b2b_w1");
        access(0, 1'b0, 1'b1, 32'h8, 32'h33333333, 0, 1'b0, "b2b_w2");
`ifdef DMEM_STALL_CNT_EN
        clr[0] = 1'b1;
        @(posedge CLK); #1;
        clr[0] = 1'b0;
`endif
        access(0, 1'b1, 1'b0, 32'h0, 32'd0, 0, 1'b1, "b2b_r0");
        access(0, 1'b1, 1'b0, 32'h4, 32'd0, 0, 1'b1, "b2b_r1");
        access(0, 1'b1, 1'b0, 32'h8, 32'd0, 0, 1'b0, "b2b_r2");
`ifdef DMEM_STALL_CNT_EN
        @(negedge CLK);
        n_checks++;
        if (sc[0] !== 16'd6) begin n_fail++; $display("FAIL stall_count got %0d want 6", sc[0]); end
        @(posedge CLK); #1;
        clr[0] = 1'b1;
        @(posedge CLK); #1;
        clr[0] = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (sc[0] !== 16'd0) begin n_fail++; $display("FAIL stall_count_clr got %0d want 0", sc[0]); end
        @(posedge CLK); #1;
        force dut_a.stall_cnt_q = 16'hFFFF;
        @(posedge CLK); #1;
        release dut_a.stall_cnt_q;
        access(0, 1'b1, 1'b0, 32'h4, 32'd0, 0, 1'b0, "sat_rd");
        @(negedge CLK);
        n_checks++;
        if (sc[0] !== 16'hFFFF) begin n_fail++; $display("FAIL stall_count_sat got %h want ffff", sc[0]); end
        @(posedge CLK); #1;
`endif
    endtask

    task automatic test_random();
        int d, kind, lat, drop;
        logic r, w;
        logic [31:0] a;
        for (int n = 0; n < 50; n++) begin
            d = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 7)) << 2;
            if (kind == 0) a = a | 32'($urandom_range(1, 3));
            if (kind == 1) a = a + 32'h100 + (32'($urandom_range(0, 3)) << 24);
            r = $urandom_range(0, 1) == 1;
            w = !r;
            if (kind == 2) begin r = 1'b1; w = 1'b1; end
            lat = r ? lat_rd[d] : lat_wr[d];
            drop = 0;
            if (lat > 1 && $urandom_range(0, 5) == 0) drop = $urandom_range(1, lat - 1);
            access(d, r, w, a, $urandom, drop, 1'b0, "random");
        end
        for (int i = 0; i < 8; i++) begin
            access(0, 1'b1, 1'b0, 32'(i) << 2, 32'd0, 0, 1'b0, "sweep_a");
            access(1, 1'b1, 1'b0, 32'(i) << 2, 32'd0, 0, 1'b0, "sweep_b");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_read();
        test_store_load();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
